seg_display_ctrl: RTL and testbench

Display controller that decides what the four-digit 7-segment display shows and scans it. It arbitrates between four sources: game-over message, hit message, pause message and normal lives/score readout. It owns a saturating BCD score counter and a hold/blink timer, and drives seg/an directly in place of a bare digit scanner. It runs on the 7-segment scan clock and sits between the game FSM and the board display pins.

---
 rtl/seg_display_ctrl.sv | 103 ++++++++++
 tb/tb_seg_display_ctrl.sv | 132 +++++++++++++
 2 files changed

// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl: arbitrates game-over/hit/pause/score contents and scans a 4-digit 7-segment display
module seg_display_ctrl #(
    parameter int HOLD_FRAMES  = 250,
    parameter int BLINK_FRAMES = 48
) (
    input  logic       segclk,
    input  logic       clr,
    input  logic [1:0] lives,
    input  logic       score_inc,
    input  logic       new_game,
    input  logic       hit_pulse,
    input  logic       paused,
    input  logic       game_over,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic [1:0] mode
);
    typedef enum logic [1:0] {NORMAL, PAUSE, HIT, OVER} mode_t;

    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] CH_E = 7'b0000110, CH_N = 7'b0101011, CH_D = 7'b0100001;
    localparam logic [6:0] CH_P = 7'b0001100, CH_A = 7'b0001000, CH_U = 7'b1000001;
    localparam logic [6:0] CH_S = 7'b0010010, CH_H = 7'b0001001, CH_I = 7'b1001111;
    localparam logic [6:0] CH_T = 7'b0000111;

    function automatic logic [6:0] digit7(input logic [3:0] d);
        case (d)
            4'd0: digit7 = 7'b1000000;
            4'd1: digit7 = 7'b1001111;
            4'd2: digit7 = 7'b0100100;
            4'd3: digit7 = 7'b0110000;
            4'd4: digit7 = 7'b0011001;
            4'd5: digit7 = 7'b0010010;
            4'd6: digit7 = 7'b0000010;
            4'd7: digit7 = 7'b1111000;
            4'd8: digit7 = 7'b0000000;
            4'd9: digit7 = 7'b0010000;
            default: digit7 = BLANK;
        endcase
    endfunction

    mode_t       mode_q, mode_nx;
    logic [1:0]  idx;
    logic [11:0] score, score_nx, snap;
    logic [7:0]  hold, hold_nx, blink, blink_nx;
    logic        pending, pending_nx, boundary, p, off, can_inc;
    logic [3:0]  nib;
    logic [6:0]  seg_nx;

    always_comb begin
        boundary   = idx == 2'd3;
        p          = ~game_over & ~new_game & (pending | hit_pulse);
        hold_nx    = new_game ? 8'd0 : p ? 8'(HOLD_FRAMES) : (hold != 8'd0 ? hold - 8'd1 : 8'd0);
        mode_nx    = game_over ? OVER : hold_nx != 8'd0 ? HIT : paused ? PAUSE : NORMAL;
        blink_nx   = (mode_nx != OVER || mode_q != OVER || blink == 8'(2 * BLINK_FRAMES - 1)) ? 8'd0 : blink + 8'd1;
        pending_nx = (new_game | game_over | boundary) ? 1'b0 : (pending | hit_pulse);
        can_inc    = score_inc & ~game_over & (mode_q != OVER) & (score != 12'h999);
        score_nx   = new_game ? 12'h000 :
                     !can_inc ? score :
                     score[3:0] != 4'd9 ? {score[11:4], score[3:0] + 4'd1} :
                     score[7:4] != 4'd9 ? {score[11:8], score[7:4] + 4'd1, 4'd0} :
                     {score[11:8] + 4'd1, 8'h00};
        off        = mode_q == OVER && blink >= 8'(BLINK_FRAMES);
        nib        = idx == 2'd0 ? {2'b00, lives} : idx == 2'd1 ? snap[11:8] : idx == 2'd2 ? snap[7:4] : snap[3:0];
        seg_nx     = BLANK;
        case (mode_q)
            NORMAL: seg_nx = digit7(nib);
            PAUSE:  seg_nx = idx == 2'd0 ? CH_P : idx == 2'd1 ? CH_A : idx == 2'd2 ? CH_U : CH_S;
            HIT:    seg_nx = idx == 2'd0 ? CH_H : idx == 2'd1 ? CH_I : idx == 2'd2 ? CH_T : BLANK;
            OVER:   seg_nx = off ? BLANK : idx == 2'd0 ? CH_E : idx == 2'd1 ? CH_N : idx == 2'd2 ? CH_D : BLANK;
            default: seg_nx = BLANK;
        endcase
    end

    // Mode, snapshot and blink only move on the idx3 edge so a frame never mixes contents
    always_ff @(posedge segclk) begin
        if (clr) begin
            idx     <= 2'd0;
            seg     <= BLANK;
            an      <= 4'b1111;
            mode_q  <= NORMAL;
            score   <= 12'h000;
            snap    <= 12'h000;
            hold    <= 8'd0;
            pending <= 1'b0;
            blink   <= 8'd0;
        end else begin
            idx     <= idx + 2'd1;
            seg     <= seg_nx;
            an      <= ~(4'b1000 >> idx);
            score   <= score_nx;
            pending <= pending_nx;
            if (boundary || new_game) hold <= hold_nx;
            if (boundary) begin
                mode_q <= mode_nx;
                snap   <= score;
                blink  <= blink_nx;
            end
        end
    end

    assign mode = mode_q;
endmodule

// File: tb/tb_seg_display_ctrl.sv
// tb_seg_display_ctrl: scoreboard bench; a frame-level model pushes expected seg/an/mode per edge
module tb_seg_display_ctrl;
    localparam int HF = 3;
    localparam int BF = 2;

    logic       segclk = 0, clr = 1, score_inc = 0, new_game = 0, hit_pulse = 0, paused = 0, game_over = 0;
    logic [1:0] lives = 2'd3;
    logic [6:0] seg;
    logic [3:0] an;
    logic [1:0] mode;

    seg_display_ctrl #(.HOLD_FRAMES(HF), .BLINK_FRAMES(BF)) dut (
        .segclk(segclk), .clr(clr), .lives(lives), .score_inc(score_inc), .new_game(new_game),
        .hit_pulse(hit_pulse), .paused(paused), .game_over(game_over), .seg(seg), .an(an), .mode(mode)
    );

    always #5 segclk = ~segclk;

    int errors = 0, checks = 0;
    int m_idx = 0, m_mode = 0, m_score = 0, m_snap = 0, m_hold = 0, m_blink = 0;
    bit m_pend = 0;
    logic [12:0] exp_q[$];

    task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at %0t: got=%b want=%b", tag, $time, got, want);
        end
    endtask

    function automatic logic [6:0] glyph(input byte c);
        case (c)
            "0": glyph = 7'b1000000; "1": glyph = 7'b1001111; "2": glyph = 7'b0100100;
            "3": glyph = 7'b0110000; "4": glyph = 7'b0011001; "5": glyph = 7'b0010010;
            "6": glyph = 7'b0000010; "7": glyph = 7'b1111000; "8": glyph = 7'b0000000;
            "9": glyph = 7'b0010000; "E": glyph = 7'b0000110; "n": glyph = 7'b0101011;
            "d": glyph = 7'b0100001; "P": glyph = 7'b0001100; "A": glyph = 7'b0001000;
            "U": glyph = 7'b1000001; "S": glyph = 7'b0010010; "H": glyph = 7'b0001001;
            "I": glyph = 7'b1001111; "t": glyph = 7'b0000111;
            default: glyph = 7'b1111111;
        endcase
    endfunction

    task automatic cyc();
        logic [6:0] es;
        logic [3:0] ea;
        logic [12:0] got;
        string txt;
        int dv, old_mode, hn;
        bit hp;
        if (clr) begin
            es = 7'h7F; ea = 4'hF;
            m_idx = 0; m_mode = 0; m_score = 0; m_snap = 0; m_hold = 0; m_blink = 0; m_pend = 0;
        end else begin
            ea = 4'hF;
            ea[3 - m_idx] = 1'b0;
            dv = m_idx == 0 ? int'(lives) : m_idx == 1 ? m_snap / 100 : m_idx == 2 ? (m_snap / 10) % 10 : m_snap % 10;
            txt = m_mode == 1 ? "PAUS" : m_mode == 2 ? "HIt " : m_mode == 3 ? (m_blink < BF ? "End " : "    ") : "";
            es = m_mode == 0 ? glyph(byte'(48 + dv)) : glyph(txt[m_idx]);
            old_mode = m_mode;
            if (m_idx == 3) begin
                hp = !game_over && !new_game && (m_pend || hit_pulse);
                hn = new_game ? 0 : hp ? HF : (m_hold > 0 ? m_hold - 1 : 0);
                m_hold = hn;
                m_mode = game_over ? 3 : hn > 0 ? 2 : paused ? 1 : 0;
                m_blink = m_mode != 3 ? 0 : old_mode != 3 ? 0 : (m_blink + 1) % (2 * BF);
                m_snap = m_score;
            end else if (new_game) m_hold = 0;
            m_pend = (new_game || game_over || m_idx == 3) ? 0 : (m_pend || hit_pulse);
            if (new_game) m_score = 0;
            else if (score_inc && !game_over && old_mode != 3 && m_score < 999) m_score++;
            m_idx = (m_idx + 1) % 4;
        end
        exp_q.push_back({es, ea, 2'(m_mode)});
        @(posedge segclk);
        #1;
        got = exp_q.pop_front();
        chk("seg", seg, got[12:6]);
        chk("an", {3'b0, an}, {3'b0, got[5:2]});
        chk("mode", {5'b0, mode}, {5'b0, got[1:0]});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic align(input int k);
        for (int i = 0; i < 4 && m_idx != k; i++) cyc();
    endtask

    initial begin
        run(2);
        clr = 0;
        run(8);
        score_inc = 1;
        run(1000);
        score_inc = 0;
        run(8);
        new_game = 1; score_inc = 1;
        cyc();
        new_game = 0; score_inc = 0;
        run(8);
        align(1);
        hit_pulse = 1; cyc(); hit_pulse = 0;
        run(7);
        hit_pulse = 1; cyc(); hit_pulse = 0;
        run(20);
        paused = 1; hit_pulse = 1; cyc(); hit_pulse = 0;
        run(24);
        paused = 0;
        run(8);
        score_inc = 1; run(5); score_inc = 0;
        game_over = 1;
        run(10);
        score_inc = 1; hit_pulse = 1; cyc(); score_inc = 0; hit_pulse = 0;
        run(25);
        game_over = 0;
        run(12);
        new_game = 1; cyc(); new_game = 0;
        score_inc = 1; run(42); score_inc = 0;
        run(4);
        hit_pulse = 1; cyc(); hit_pulse = 0;
        run(6);
        lives = 2'd1;
        align(2);
        clr = 1; cyc(); clr = 0;
        run(8);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
